wptr_full_sync: RTL and testbench

//  Write-side pointer/flag block for the async FIFO, generation 2. Holds the binary/Gray write

---
 rtl/wptr_full_sync.sv | 83 ++++++++
 tb/tb_wptr_full_sync.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/wptr_full_sync.sv
// Write-side pointer/flag block for the async FIFO: binary/Gray write pointer,
// read-pointer synchroniser, full, almost-full, fill count and sticky overflow.
`timescale 1ns/1ps
module wptr_full_sync #(
  parameter int unsigned PTR_WIDTH   = 5,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 wr_clk_i,
  input  logic                 rstn_i,
  input  logic                 wr_en_i,
  input  logic [PTR_WIDTH:0]   rptr_gray_i,
  input  logic [PTR_WIDTH:0]   afull_thresh_i,
  input  logic                 ovf_clr_i,
  output logic [PTR_WIDTH:0]   wptr_gray_o,
  output logic [PTR_WIDTH:0]   wptr_bin_o,
  output logic [PTR_WIDTH-1:0] wr_addr_o,
  output logic                 wr_full_o,
  output logic                 wr_afull_o,
  output logic [PTR_WIDTH:0]   wr_cnt_o,
  output logic                 wr_ovf_o
);

  logic [SYNC_STAGES-1:0][PTR_WIDTH:0] sync_q, sync_d;
  logic [PTR_WIDTH:0] wptr_bin_q, wptr_bin_d;
  logic [PTR_WIDTH:0] wptr_gray_q, wptr_gray_d;
  logic [PTR_WIDTH:0] cnt_q, cnt_d;
  logic               full_q, full_d;
  logic               afull_q, afull_d;
  logic               ovf_q, ovf_d;

  logic               push;
  logic [PTR_WIDTH:0] rq_gray;
  logic [PTR_WIDTH:0] rq_bin;

  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], rptr_gray_i};
    rq_gray     = sync_q[SYNC_STAGES-1];
    rq_bin      = '0;
    // Gray-to-binary: each bit is the XOR of all Gray bits at or above it
    for (int unsigned i = 0; i <= PTR_WIDTH; i++) begin
      rq_bin[i] = ^(rq_gray >> i);
    end

    push        = wr_en_i & ~full_q;
    wptr_bin_d  = wptr_bin_q + {{PTR_WIDTH{1'b0}}, push};
    wptr_gray_d = wptr_bin_d ^ (wptr_bin_d >> 1);
    cnt_d       = wptr_bin_d - rq_bin;

    // Full when the next write pointer is one lap ahead of the synchronised read pointer
    full_d      = (wptr_gray_d == {~rq_gray[PTR_WIDTH:PTR_WIDTH-1], rq_gray[PTR_WIDTH-2:0]});
    afull_d     = (afull_thresh_i != '0) && (cnt_d >= afull_thresh_i);
    ovf_d       = (wr_en_i & full_q) | (ovf_q & ~ovf_clr_i);
  end

  always_ff @(posedge wr_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync_q      <= '0;
      wptr_bin_q  <= '0;
      wptr_gray_q <= '0;
      cnt_q       <= '0;
      full_q      <= 1'b0;
      afull_q     <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      wptr_bin_q  <= wptr_bin_d;
      wptr_gray_q <= wptr_gray_d;
      cnt_q       <= cnt_d;
      full_q      <= full_d;
      afull_q     <= afull_d;
      ovf_q       <= ovf_d;
    end
  end

  assign wptr_gray_o = wptr_gray_q;
  assign wptr_bin_o  = wptr_bin_q;
  assign wr_addr_o   = wptr_bin_q[PTR_WIDTH-1:0];
  assign wr_full_o   = full_q;
  assign wr_afull_o  = afull_q;
  assign wr_cnt_o    = cnt_q;
  assign wr_ovf_o    = ovf_q;

endmodule

// File: tb/tb_wptr_full_sync.sv
// Directed bench for wptr_full_sync (PTR_WIDTH=5, SYNC_STAGES=2, DEPTH=32),
// with an asynchronous model reader for the streaming section.
`timescale 1ns/1ps
module tb_wptr_full_sync;

  logic       wr_clk_i = 1'b0;
  logic       rd_clk   = 1'b0;
  logic       rstn_i   = 1'b1;
  logic       wr_en_i  = 1'b0;
  logic       ovf_clr_i = 1'b0;
  logic [5:0] afull_thresh_i = '0;
  logic [5:0] rptr_gray_i;
  logic [5:0] rptr_man = '0;
  logic       rd_run = 1'b0;
  int         rd_cnt = 0;
  int         wr_acc = 0;

  logic [5:0] wptr_gray_o, wptr_bin_o, wr_cnt_o;
  logic [4:0] wr_addr_o;
  logic       wr_full_o, wr_afull_o, wr_ovf_o;

  int n_cmp = 0;
  int n_err = 0;

  wptr_full_sync #(.PTR_WIDTH(5), .SYNC_STAGES(2)) dut (
    .wr_clk_i       (wr_clk_i),
    .rstn_i         (rstn_i),
    .wr_en_i        (wr_en_i),
    .rptr_gray_i    (rptr_gray_i),
    .afull_thresh_i (afull_thresh_i),
    .ovf_clr_i      (ovf_clr_i),
    .wptr_gray_o    (wptr_gray_o),
    .wptr_bin_o     (wptr_bin_o),
    .wr_addr_o      (wr_addr_o),
    .wr_full_o      (wr_full_o),
    .wr_afull_o     (wr_afull_o),
    .wr_cnt_o       (wr_cnt_o),
    .wr_ovf_o       (wr_ovf_o)
  );

  always #5 wr_clk_i = ~wr_clk_i;
  initial begin
    #0.3;
    forever #3.5 rd_clk = ~rd_clk;
  end

  function automatic logic [5:0] to_gray(input logic [5:0] b);
    return b ^ (b >> 1);
  endfunction

  // Model reader: consumes only words already written, at a random rate
  always @(posedge rd_clk) begin
    if (!rd_run) rd_cnt <= 0;
    else if (wr_acc > rd_cnt && $urandom_range(0, 3) != 0) rd_cnt <= rd_cnt + 1;
  end
  assign rptr_gray_i = rd_run ? to_gray(rd_cnt[5:0]) : rptr_man;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge wr_clk_i);
    #1;
  endtask

  task automatic do_reset(input string tag);
    wr_en_i   = 1'b0;
    ovf_clr_i = 1'b0;
    rptr_man  = '0;
    rstn_i    = 1'b0;
    #1;
    check_eq({tag, "_gray"},  32'(wptr_gray_o), 0);
    check_eq({tag, "_bin"},   32'(wptr_bin_o),  0);
    check_eq({tag, "_addr"},  32'(wr_addr_o),   0);
    check_eq({tag, "_full"},  32'(wr_full_o),   0);
    check_eq({tag, "_afull"}, 32'(wr_afull_o),  0);
    check_eq({tag, "_cnt"},   32'(wr_cnt_o),    0);
    check_eq({tag, "_ovf"},   32'(wr_ovf_o),    0);
    @(negedge wr_clk_i);
    rstn_i = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic       acc;
    logic [5:0] exp_bin;
    logic [5:0] prev_gray;
    int         cyc;

    #2;
    do_reset("rst0");

    // 1: fill from empty with a static read pointer
    wr_en_i = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (k == 31) begin
        check_eq("t1_full31", 32'(wr_full_o), 0);
        check_eq("t1_bin31",  32'(wptr_bin_o), 31);
      end
      if (k == 32) begin
        check_eq("t1_full32", 32'(wr_full_o), 1);
        check_eq("t1_bin32",  32'(wptr_bin_o), 32);
        check_eq("t1_cnt32",  32'(wr_cnt_o), 32);
        check_eq("t1_ovf32",  32'(wr_ovf_o), 0);
        check_eq("t1_gray32", 32'(wptr_gray_o), 48);
      end
      if (k == 33) check_eq("t1_ovf33", 32'(wr_ovf_o), 1);
      if (k == 40) begin
        check_eq("t1_bin40",  32'(wptr_bin_o), 32);
        check_eq("t1_full40", 32'(wr_full_o), 1);
      end
    end

    // 2: overflow clear, and set winning over clear
    wr_en_i = 1'b0; ovf_clr_i = 1'b1;
    tick();
    check_eq("t2_clr", 32'(wr_ovf_o), 0);
    wr_en_i = 1'b1; ovf_clr_i = 1'b1;
    tick();
    check_eq("t2_setwins", 32'(wr_ovf_o), 1);
    wr_en_i = 1'b0; ovf_clr_i = 1'b0;

    // 3: one read releases full after SYNC_STAGES+1 clocks
    rptr_man = 6'b000001;
    tick();
    check_eq("t3_full_c1", 32'(wr_full_o), 1);
    tick();
    check_eq("t3_full_c2", 32'(wr_full_o), 1);
    check_eq("t3_cnt_c2",  32'(wr_cnt_o), 32);
    tick();
    check_eq("t3_full_c3", 32'(wr_full_o), 0);
    check_eq("t3_cnt_c3",  32'(wr_cnt_o), 31);
    wr_en_i = 1'b1;
    tick();
    check_eq("t3_refill_bin",  32'(wptr_bin_o), 33);
    check_eq("t3_refill_gray", 32'(wptr_gray_o), 49);
    check_eq("t3_refill_full", 32'(wr_full_o), 1);
    check_eq("t3_refill_cnt",  32'(wr_cnt_o), 32);
    wr_en_i = 1'b0;

    // 4: almost-full threshold, disable and out-of-range levels
    do_reset("rst4");
    afull_thresh_i = 6'd28;
    wr_en_i = 1'b1;
    for (int k = 1; k <= 28; k++) begin
      tick();
      if (k == 27) begin
        check_eq("t4_afull27", 32'(wr_afull_o), 0);
        check_eq("t4_cnt27",   32'(wr_cnt_o), 27);
      end
      if (k == 28) check_eq("t4_afull28", 32'(wr_afull_o), 1);
    end
    do_reset("rst4b");
    afull_thresh_i = 6'd0;
    wr_en_i = 1'b1;
    for (int k = 1; k <= 34; k++) begin
      tick();
      if (k == 1 || k == 28 || k == 32 || k == 34)
        check_eq($sformatf("t4_thr0_k%0d", k), 32'(wr_afull_o), 0);
    end
    afull_thresh_i = 6'd33;
    tick();
    check_eq("t4_thr33", 32'(wr_afull_o), 0);
    afull_thresh_i = 6'd32;
    tick();
    check_eq("t4_thr32", 32'(wr_afull_o), 1);
    wr_en_i = 1'b0;

    // 5: stream 200 writes against the asynchronous reader
    do_reset("rst5");
    afull_thresh_i = 6'd0;
    wr_acc  = 0;
    exp_bin = '0;
    cyc     = 0;
    rd_run  = 1'b1;
    while (wr_acc < 200 && cyc < 2000) begin
      wr_en_i   = ($urandom_range(0, 4) != 0);
      acc       = wr_en_i && !wr_full_o;
      prev_gray = wptr_gray_o;
      tick();
      cyc++;
      if (acc) begin
        wr_acc++;
        exp_bin = exp_bin + 6'd1;
      end
      check_eq("t5_bin",     32'(wptr_bin_o), 32'(exp_bin));
      check_eq("t5_gray",    32'(wptr_gray_o), 32'(to_gray(exp_bin)));
      check_eq("t5_gray1b",  32'($countones(prev_gray ^ wptr_gray_o) <= 1), 1);
      check_eq("t5_cnt_ge",  32'(int'(wr_cnt_o) >= wr_acc - rd_cnt), 1);
      check_eq("t5_cnt_max", 32'(wr_cnt_o <= 6'd32), 1);
    end
    check_eq("t5_done", 32'(wr_acc >= 200), 1);

    // 6: asynchronous reset mid-stream, then first write lands at address 0
    wr_en_i = 1'b1;
    @(posedge wr_clk_i);
    #3;
    rd_run = 1'b0;
    do_reset("t6_rst");
    wr_en_i = 1'b1;
    #1;
    check_eq("t6_addr_first", 32'(wr_addr_o), 0);
    tick();
    check_eq("t6_bin_after", 32'(wptr_bin_o), 1);
    check_eq("t6_addr_after", 32'(wr_addr_o), 1);
    wr_en_i = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
